// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// requester count and the rotating priority scan.
package rr_arbiter_4_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_NREQ = 4;

    // First requester found scanning last_id+1 .. last_id+4 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [ARB_NREQ-1:0] req,
                                           input logic [1:0]          last_id);
        logic [1:0] idx;
        logic       found;
        rr_pick = last_id;
        found   = 1'b0;
        for (int k = 1; k <= ARB_NREQ; k++) begin
            idx = last_id + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 one-hot decoder shared with the MUX datapath select logic.
module decoder_2x4 (
    input  logic [1:0] A,
    output logic [3:0] D
);

    always_comb begin
        D = 4'b0001 << A;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with done/drop/hold-limit release.
// state | meaning: IDLE = no owner, arbitrate on req; GRANT = gnt_id owns the resource
module rr_arbiter_4
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    import rr_arbiter_4_pkg::*;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] last_id_q, last_id_d;
    logic       rel_c;
    logic [ARB_NREQ-1:0] dec_out;

    assign rel_c = done || !req[gnt_id_q] || (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (req != 4'b0000) begin
                    state_d     = ARB_GRANT;
                    gnt_id_d    = rr_pick(req, last_id_q);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                end
            end
            ARB_GRANT: begin
                if (rel_c) begin
                    state_d     = ARB_IDLE;
                    gnt_valid_d = 1'b0;
                    last_id_d   = gnt_id_q;
                    // Hold limit only counts as a timeout when nothing else released.
                    timeout_d   = !done && req[gnt_id_q];
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
            last_id_q   <= 2'd3;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    decoder_2x4 uut_dec (
        .A (gnt_id_q),
        .D (dec_out)
    );

    assign gnt       = dec_out & {4{gnt_valid_q}};
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed cycle table followed by random traffic
// checked against a grant-ownership model.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic [3:0] g, input logic v,
                                input logic [1:0] i, input logic t);
        vec_t x;
        x.rst = r; x.req = rq; x.done = d;
        x.gnt = g; x.vld = v; x.id = i; x.to = t;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int step,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] rq, input logic d);
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int step, input logic [3:0] g,
                             input logic v, input logic [1:0] i, input logic t);
        check({tag, ".gnt"}, step, {4'b0, gnt}, {4'b0, g});
        check({tag, ".valid"}, step, {7'b0, gnt_valid}, {7'b0, v});
        check({tag, ".id"}, step, {6'b0, gnt_id}, {6'b0, i});
        check({tag, ".timeout"}, step, {7'b0, timeout}, {7'b0, t});
    endtask

    // Reference model: who owns the resource and for how many cycles so far.
    bit m_busy;
    int m_id, m_last, m_held;
    bit m_to;

    function automatic void model_step(input logic r, input logic [3:0] rq, input logic d);
        m_to = 0;
        if (r) begin
            m_busy = 0; m_id = 0; m_last = 3; m_held = 0;
        end else if (!m_busy) begin
            if (rq != 0) begin
                for (int k = 4; k >= 1; k--)
                    if (rq[(m_last + k) % 4]) m_id = (m_last + k) % 4;
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            if (d || !rq[m_id] || m_held == MAX_HOLD) begin
                m_to   = !d && rq[m_id];
                m_busy = 0;
                m_last = m_id;
            end else begin
                m_held++;
            end
        end
    endfunction

    initial begin
        logic [3:0] rq;
        logic       d, r;

        rst = 1'b1; req = 4'b0000; done = 1'b0;

        // reset, then idle
        add(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // all request, done one cycle after each grant: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            add(0, 4'b1111, 0, 4'b0001 << (i % 4), 1, 2'(i % 4), 0);
            add(0, 4'b1111, 1, 4'b0000, 0, 2'(i % 4), 0);
        end
        // lone requester 2 runs into the hold limit, then is regranted
        add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        add(0, 4'b0100, 0, 4'b0000, 0, 2'd2, 1);
        add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        // done in the last allowed cycle wins over the hold limit
        for (int i = 0; i < 7; i++) add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        add(0, 4'b0100, 1, 4'b0000, 0, 2'd2, 0);
        // owner 1 drops its request; 3 wins after last_id=1
        add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b1001, 0, 4'b0000, 0, 2'd1, 0);
        add(0, 4'b1001, 0, 4'b1000, 1, 2'd3, 0);
        add(0, 4'b1001, 1, 4'b0000, 0, 2'd3, 0);
        // reset mid-grant, then 0 has first priority
        add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        add(1, 4'b0010, 0, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);

        #2;
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].done);
            check_all("dir", i, vecs[i].gnt, vecs[i].vld, vecs[i].id, vecs[i].to);
        end

        // random traffic with sticky requests so long grants and timeouts occur
        apply(1, 4'b0000, 0);
        model_step(1, 4'b0000, 0);
        rq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 299) == 0);
            apply(r, rq, d);
            model_step(r, rq, d);
            check_all("rnd", c, m_busy ? (4'b0001 << m_id) : 4'b0000,
                      m_busy, 2'(m_id), m_to);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
